// File: rtl/wb_stage.sv
// -----------------------------------------------------------------------------
// wb_stage
// Write-back end of the register-file interface. Captures each retiring
// instruction from the MEM stage into the MEM/WB register, selects the ALU
// result or the load data, and drives the ID-stage register-file write port.
// While a load waits on the SRAM response, `freeze` stalls IF/ID/EXE/MEM.
//
// Optional feature macro: WB_LOAD_TIMEOUT_EN
//   Defined   : a load that waits TIMEOUT_CYCLES in LOAD_WAIT is retired with
//               value 0 and the sticky load_error flag is set.
//   Undefined : LOAD_WAIT lasts until mem_ready; load_error is tied 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   wb_enable_in    MEM-stage instruction writes a register
//   mem_read_in     MEM-stage instruction is a load
//   alu_result_in   ALU result (32)
//   dest_in         destination register (4)
//   mem_data_in     SRAM read data (32), valid with mem_ready
//   mem_ready       SRAM response strobe
//   wb_dest         register-file write address (4)
//   wb_value        register-file write data (32)
//   wb_enable_WB    register-file write enable
//   freeze          combinational upstream stall
//   load_error      sticky load-timeout flag
//
// States:
//   IDLE      | instructions retire every cycle
//   LOAD_WAIT | a load is parked waiting for mem_ready; upstream frozen
// -----------------------------------------------------------------------------
module wb_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_enable_in,
    input  logic        mem_read_in,
    input  logic [31:0] alu_result_in,
    input  logic [3:0]  dest_in,
    input  logic [31:0] mem_data_in,
    input  logic        mem_ready,
    output logic [3:0]  wb_dest,
    output logic [31:0] wb_value,
    output logic        wb_enable_WB,
    output logic        freeze,
    output logic        load_error
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 1023) begin : g_bad_timeout
        $error("wb_stage: TIMEOUT_CYCLES must be in 1..1023");
    end

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t      r_state;
    logic [3:0]  r_pend;
    logic        r_wen;
    logic [3:0]  r_dest;
    logic [31:0] r_value;

    logic w_load;
    logic w_timeout;

    assign w_load = mem_read_in & wb_enable_in;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    logic [CW-1:0] r_cnt;
    logic          r_load_error;

    // mem_ready takes priority, so a timeout only fires when no data arrives.
    assign w_timeout  = (r_state == LOAD_WAIT) && !mem_ready &&
                        (r_cnt == CW'(TIMEOUT_CYCLES));
    assign load_error = r_load_error;
`else
    assign w_timeout  = 1'b0;
    assign load_error = 1'b0;
`endif

    // Gated by rst so the stall drops immediately on reset even if the MEM
    // stage is still presenting a load.
    assign freeze = !rst &&
                    (((r_state == IDLE) && w_load && !mem_ready) ||
                     ((r_state == LOAD_WAIT) && !mem_ready && !w_timeout));

    assign wb_enable_WB = r_wen;
    assign wb_dest      = r_dest;
    assign wb_value     = r_value;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_pend  <= '0;
            r_wen   <= 1'b0;
            r_dest  <= '0;
            r_value <= '0;
`ifdef WB_LOAD_TIMEOUT_EN
            r_cnt        <= '0;
            r_load_error <= 1'b0;
`endif
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_load && mem_ready) begin
                        r_wen   <= 1'b1;
                        r_dest  <= dest_in;
                        r_value <= mem_data_in;
                    end else if (w_load) begin
                        r_wen   <= 1'b0;
                        r_dest  <= dest_in;
                        r_value <= '0;
                        r_pend  <= dest_in;
                        r_state <= LOAD_WAIT;
`ifdef WB_LOAD_TIMEOUT_EN
                        r_cnt   <= '0;
`endif
                    end else begin
                        // Includes mem_read_in without wb_enable_in (a bubble).
                        r_wen   <= wb_enable_in;
                        r_dest  <= dest_in;
                        r_value <= alu_result_in;
                    end
                end
                LOAD_WAIT: begin
                    if (mem_ready) begin
                        r_wen   <= 1'b1;
                        r_dest  <= r_pend;
                        r_value <= mem_data_in;
                        r_state <= IDLE;
                    end else if (w_timeout) begin
                        r_wen   <= 1'b1;
                        r_dest  <= r_pend;
                        r_value <= '0;
                        r_state <= IDLE;
`ifdef WB_LOAD_TIMEOUT_EN
                        r_load_error <= 1'b1;
`endif
                    end else begin
                        r_wen <= 1'b0;
`ifdef WB_LOAD_TIMEOUT_EN
                        r_cnt <= r_cnt + CW'(1);
`endif
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// -----------------------------------------------------------------------------
// tb_wb_stage
// Directed, table-driven bench for wb_stage. Inputs change 1 time unit after
// the rising edge; freeze is sampled on the falling edge of the same cycle and
// the registered write-back outputs 1 time unit after the following edge.
// -----------------------------------------------------------------------------
module tb_wb_stage;

`ifdef WB_LOAD_TIMEOUT_EN
    localparam int TO = 4;
`else
    localparam int TO = 255;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_enable_in;
    logic        mem_read_in;
    logic [31:0] alu_result_in;
    logic [3:0]  dest_in;
    logic [31:0] mem_data_in;
    logic        mem_ready;
    logic [3:0]  wb_dest;
    logic [31:0] wb_value;
    logic        wb_enable_WB;
    logic        freeze;
    logic        load_error;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    wb_stage #(.TIMEOUT_CYCLES(TO)) dut (
        .clk           (clk),
        .rst           (rst),
        .wb_enable_in  (wb_enable_in),
        .mem_read_in   (mem_read_in),
        .alu_result_in (alu_result_in),
        .dest_in       (dest_in),
        .mem_data_in   (mem_data_in),
        .mem_ready     (mem_ready),
        .wb_dest       (wb_dest),
        .wb_value      (wb_value),
        .wb_enable_WB  (wb_enable_WB),
        .freeze        (freeze),
        .load_error    (load_error)
    );

    typedef struct {
        logic        wen;
        logic        mrd;
        logic [31:0] alu;
        logic [3:0]  dest;
        logic [31:0] mdata;
        logic        mrdy;
        logic        e_frz;
        logic        e_wen;
        logic [3:0]  e_dest;
        logic [31:0] e_val;
        logic        chk_dv;
    } vec_t;

    localparam int NV = 12;
    vec_t vt[NV];

    function automatic vec_t mk(logic wen, logic mrd, logic [31:0] alu, logic [3:0] dest,
                                logic [31:0] mdata, logic mrdy, logic e_frz, logic e_wen,
                                logic [3:0] e_dest, logic [31:0] e_val, logic chk_dv);
        vec_t v;
        v.wen = wen; v.mrd = mrd; v.alu = alu; v.dest = dest; v.mdata = mdata;
        v.mrdy = mrdy; v.e_frz = e_frz; v.e_wen = e_wen; v.e_dest = e_dest;
        v.e_val = e_val; v.chk_dv = chk_dv;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic wen, input logic mrd, input logic [31:0] alu,
                         input logic [3:0] dest, input logic [31:0] mdata, input logic mrdy);
        wb_enable_in  = wen;
        mem_read_in   = mrd;
        alu_result_in = alu;
        dest_in       = dest;
        mem_data_in   = mdata;
        mem_ready     = mrdy;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_wb(input string nm, input logic e_wen, input logic [3:0] e_dest,
                            input logic [31:0] e_val);
        check({nm, ".wen"},   {31'd0, wb_enable_WB}, {31'd0, e_wen});
        check({nm, ".dest"},  {28'd0, wb_dest},      {28'd0, e_dest});
        check({nm, ".value"}, wb_value,              e_val);
    endtask

    initial begin
        // in, exp: freeze, wen, dest, value, check dest/value
        vt[0]  = mk(1, 0, 32'h0000_00AA, 4'd3, 32'h0,         0, 0, 1, 4'd3, 32'h0000_00AA, 1);
        vt[1]  = mk(0, 0, 32'h0000_0055, 4'd9, 32'h0,         0, 0, 0, 4'd9, 32'h0000_0055, 1);
        vt[2]  = mk(0, 1, 32'h0000_0077, 4'd5, 32'h0,         0, 0, 0, 4'd5, 32'h0000_0077, 1);
        vt[3]  = mk(1, 1, 32'h0000_0000, 4'd7, 32'hDEAD_BEEF, 1, 0, 1, 4'd7, 32'hDEAD_BEEF, 1);
        vt[4]  = mk(1, 0, 32'h0000_0011, 4'd1, 32'hFFFF_FFFF, 1, 0, 1, 4'd1, 32'h0000_0011, 1);
        vt[5]  = mk(1, 1, 32'h0000_0099, 4'd2, 32'h0,         0, 1, 0, 4'd2, 32'h0,         1);
        vt[6]  = mk(1, 1, 32'h0000_0099, 4'd2, 32'h0,         0, 1, 0, 4'd0, 32'h0,         0);
        vt[7]  = mk(1, 1, 32'h0000_0099, 4'd2, 32'h0,         0, 1, 0, 4'd0, 32'h0,         0);
        vt[8]  = mk(1, 1, 32'h0000_0099, 4'd2, 32'h1234_5678, 1, 0, 1, 4'd2, 32'h1234_5678, 1);
        vt[9]  = mk(1, 1, 32'h0000_0000, 4'd4, 32'h0,         0, 1, 0, 4'd4, 32'h0,         1);
        vt[10] = mk(1, 1, 32'h0000_0000, 4'd4, 32'hCAFE_0001, 1, 0, 1, 4'd4, 32'hCAFE_0001, 1);
        vt[11] = mk(1, 0, 32'hFFFF_FFFF, 4'hF, 32'h0,         0, 0, 1, 4'hF, 32'hFFFF_FFFF, 1);

        rst = 1'b1;
        drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
        next_cycle();
        next_cycle();
        check_wb("reset", 0, 4'h0, 32'h0);
        check("reset.freeze", {31'd0, freeze}, 32'd0);
        check("reset.load_error", {31'd0, load_error}, 32'd0);
        rst = 1'b0;

        // ---- table: single-cycle ops, zero-wait load, 3-cycle load, back-to-back
        for (int i = 0; i < NV; i++) begin
            drive(vt[i].wen, vt[i].mrd, vt[i].alu, vt[i].dest, vt[i].mdata, vt[i].mrdy);
            @(negedge clk);
            check($sformatf("vec%0d.freeze", i), {31'd0, freeze}, {31'd0, vt[i].e_frz});
            next_cycle();
            check($sformatf("vec%0d.wen", i), {31'd0, wb_enable_WB}, {31'd0, vt[i].e_wen});
            if (vt[i].chk_dv) begin
                check($sformatf("vec%0d.dest", i), {28'd0, wb_dest}, {28'd0, vt[i].e_dest});
                check($sformatf("vec%0d.value", i), wb_value, vt[i].e_val);
            end
        end

        // ---- asynchronous reset mid-stream (outputs currently 1,F,FFFFFFFF)
        rst = 1'b1;
        #1;
        check_wb("async_rst", 0, 4'h0, 32'h0);
        check("async_rst.freeze", {31'd0, freeze}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // ---- reset in LOAD_WAIT cycle 2, then a stray mem_ready
        drive(1, 1, 32'h0, 4'd6, 32'h0, 0);
        @(negedge clk);
        check("rstwait.freeze0", {31'd0, freeze}, 32'd1);
        next_cycle();
        next_cycle();
        check("rstwait.frozen", {31'd0, freeze}, 32'd1);
        rst = 1'b1;
        #1;
        check_wb("rstwait.rst", 0, 4'h0, 32'h0);
        check("rstwait.rst_freeze", {31'd0, freeze}, 32'd0);
        next_cycle();
        drive(0, 0, 32'h0, 4'h0, 32'h5A5A_5A5A, 1);
        rst = 1'b0;
        @(negedge clk);
        check("rstwait.stray_freeze", {31'd0, freeze}, 32'd0);
        next_cycle();
        check_wb("rstwait.stray", 0, 4'h0, 32'h0);
        drive(1, 0, 32'h0000_0123, 4'hC, 32'h0, 0);
        next_cycle();
        check_wb("rstwait.idle_alu", 1, 4'hC, 32'h0000_0123);

`ifdef WB_LOAD_TIMEOUT_EN
        // ---- timeout: counter 0..TO over TO+1 LOAD_WAIT cycles, fires at TO
        drive(1, 1, 32'h0, 4'd8, 32'h0, 0);
        @(negedge clk);
        check("to.freeze_N", {31'd0, freeze}, 32'd1);
        for (int c = 1; c <= TO; c++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("to.freeze_N+%0d", c), {31'd0, freeze}, 32'd1);
            check($sformatf("to.wen_N+%0d", c), {31'd0, wb_enable_WB}, 32'd0);
        end
        next_cycle();
        @(negedge clk);
        check("to.freeze_fire", {31'd0, freeze}, 32'd0);
        next_cycle();
        drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
        check_wb("to.write", 1, 4'd8, 32'h0);
        check("to.load_error", {31'd0, load_error}, 32'd1);
        next_cycle();
        check("to.sticky", {31'd0, load_error}, 32'd1);
        rst = 1'b1;
        #1;
        check("to.rst_clears", {31'd0, load_error}, 32'd0);
        next_cycle();
        rst = 1'b0;

        // ---- mem_ready on the timeout cycle wins
        drive(1, 1, 32'h0, 4'd8, 32'h0, 0);
        for (int c = 1; c <= TO + 1; c++) next_cycle();
        drive(1, 1, 32'h0, 4'd8, 32'h0000_ABCD, 1);
        @(negedge clk);
        check("tor.freeze", {31'd0, freeze}, 32'd0);
        next_cycle();
        drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
        check_wb("tor.write", 1, 4'd8, 32'h0000_ABCD);
        check("tor.load_error", {31'd0, load_error}, 32'd0);
`else
        // ---- without the timeout the load waits indefinitely
        drive(1, 1, 32'h0, 4'hA, 32'h0, 0);
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check($sformatf("long.freeze%0d", c), {31'd0, freeze}, 32'd1);
            next_cycle();
            check($sformatf("long.wen%0d", c), {31'd0, wb_enable_WB}, 32'd0);
        end
        drive(1, 1, 32'h0, 4'hA, 32'h0BAD_F00D, 1);
        @(negedge clk);
        check("long.freeze_end", {31'd0, freeze}, 32'd0);
        next_cycle();
        drive(0, 0, 32'h0, 4'h0, 32'h0, 0);
        check_wb("long.write", 1, 4'hA, 32'h0BAD_F00D);
        check("long.load_error", {31'd0, load_error}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

- Write-back end of the register-file interface.
- Sits between the MEM stage and the ID stage.
- Registers each retiring instruction into a MEM/WB pipeline register and selects the ALU result or the load data.
- Drives the ID stage's register-file write port (`wb_dest`, `wb_value`, `wb_enable_WB`), and freezes upstream stages while a load waits on the SRAM response.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, 255: max cycles spent in LOAD_WAIT; used only with `WB_LOAD_TIMEOUT_EN`. Legal range 1..1023.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `wb_enable_in` in 1: MEM-stage instruction writes a register.
- `mem_read_in` in 1: MEM-stage instruction is a load.
- `alu_result_in` in 32: ALU result from MEM stage.
- `dest_in` in 4: destination register (Rd).
- `mem_data_in` in 32: SRAM read data, valid when `mem_ready`=1.
- `mem_ready` in 1: SRAM response strobe, one cycle per load.
- `wb_dest` out 4: register-file write address.
- `wb_value` out 32: register-file write data.
- `wb_enable_WB` out 1: register-file write enable.
- `freeze` out 1: stall IF/ID/EXE/MEM; combinational.
- `load_error` out 1: sticky load-timeout flag; constant 0 without `WB_LOAD_TIMEOUT_EN`.

## Operation
- A load is `mem_read_in & wb_enable_in`.
- `mem_read_in` without `wb_enable_in` is captured as a bubble.
- MEM/WB register R = {wen, dest, value}. Outputs are driven directly from R: `wb_enable_WB`=R.wen, `wb_dest`=R.dest, `wb_value`=R.value.
- Two states, IDLE and LOAD_WAIT; a pending-destination register P holds Rd of the waiting load.
- In IDLE, per cycle:
  - Non-load: R <= {`wb_enable_in`, `dest_in`, `alu_result_in`}.
  - Load with `mem_ready`=1: R <= {1, `dest_in`, `mem_data_in`} (zero-wait).
  - Load with `mem_ready`=0: R <= {0, `dest_in`, 0}, P <= `dest_in`, go to LOAD_WAIT.
- In LOAD_WAIT:
  - Inputs are held stable by `freeze`; R.wen stays 0 (bubbles written).
  - On `mem_ready`=1: R <= {1, P, `mem_data_in`}, go to IDLE.
- `freeze` = (IDLE & load & ~`mem_ready`) | (LOAD_WAIT & ~`mem_ready`).
  - `freeze` drops in the cycle `mem_ready` arrives, so upstream advances on that same edge and the next instruction is presented in the following cycle.
- `mem_ready` in IDLE with no load presented is ignored.
- Reset, at any time including mid-LOAD_WAIT:
  - R cleared, so `wb_enable_WB`=0, `wb_dest`=0, `wb_value`=0.
  - P=0, state IDLE, `freeze`=0, `load_error`=0, timeout counter 0.
  - A pending load is discarded; a `mem_ready` arriving after reset is ignored.

## Timing
- Non-load or zero-wait load presented in cycle N: write-back outputs valid in cycle N+1, for one cycle.
- Load with `mem_ready` in cycle N+k (k≥1):
  - `freeze`=1 in cycles N..N+k-1.
  - `wb_enable_WB`=1 with the load data in cycle N+k+1.
- Back-to-back loads are allowed. Each waits independently; there is no overlap, since the second load is not presented until the first completes.
- The register file writes on its own edge. The ID stage sees the value according to the register file's write/read ordering; this block adds no bypass.

## Configuration
- `WB_LOAD_TIMEOUT_EN` defined:
  - A counter (width ceil(log2(TIMEOUT_CYCLES+1))) clears on entry to LOAD_WAIT and increments each LOAD_WAIT cycle without `mem_ready`.
  - When it equals `TIMEOUT_CYCLES`: R <= {1, P, 32'h0}, `load_error` <= 1 (sticky until reset), go to IDLE, `freeze`=0 in that cycle.
  - `mem_ready` and timeout in the same cycle: `mem_ready` wins; data is written and `load_error` is unchanged.
- Not defined: LOAD_WAIT lasts indefinitely; no counter; `load_error` tied 0.

## Test plan
- Reset: `rst` pulse mid-stream → all outputs 0, `freeze`=0 in the same cycle (asynchronous).
- ALU op (`wb_enable_in`=1, `dest_in`=4'd3, `alu_result_in`=32'h0000_00AA) in cycle 5 → `wb_enable_WB`=1, `wb_dest`=3, `wb_value`=32'hAA in cycle 6.
- Zero-wait load: `dest_in`=4'd7, `mem_ready`=1, `mem_data_in`=32'hDEAD_BEEF → written next cycle with `freeze` never asserted.
- 3-cycle load: `dest_in`=4'd2, `mem_ready` high only on cycle N+3 with 32'h1234_5678 → `freeze`=1 for N..N+2, `wb_enable_WB`=0 for N+1..N+3, then writes (2, 32'h1234_5678) in N+4.
- Reset asserted in LOAD_WAIT cycle 2, then `mem_ready` pulsed after release → no write, `freeze`=0, state IDLE.
- With `WB_LOAD_TIMEOUT_EN`, `TIMEOUT_CYCLES`=4, `mem_ready` never asserted → write (P, 32'h0) and `load_error`=1; repeat with `mem_ready` on the timeout cycle → data written, `load_error`=0.
